pdp8_stim_sequencer: RTL and testbench

// - Synthesisable, parametrised instruction stimulus sequencer for the PDP-8 execution unit.
// - Replaces the behavioural decode model in unit-level and emulation benches.
// - Issues a fixed preamble (CLA CLL, then NOP), followed by NUM_INSTR pseudo-random

---
 rtl/pdp8_pkg.sv | 51 +++++
 rtl/pdp8_lfsr32.sv | 28 ++
 rtl/pdp8_stim_sequencer.sv | 152 +++++++++++++++
 tb/tb_pdp8_stim_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared types, opcodes and helpers for the PDP-8 stimulus sequencer.
package pdp8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_CLA,
    PRE_NOP,
    RAND,
    HOLD,
    DONE
  } stim_state_e;

  typedef enum logic [1:0] {
    MODE_MEM = 2'b00,
    MODE_OP7 = 2'b01,
    MODE_ALT = 2'b10,
    MODE_RAW = 2'b11
  } stim_mode_e;

  localparam logic [11:0] OP_CLA_CLL = 12'o7300;
  localparam logic [11:0] OP_NOP     = 12'o7000;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Memory-reference word: opcodes 6 (IOT) and 7 (OPR) fold down to 0 and 1.
  function automatic logic [11:0] mem_ref_word(input logic [11:0] r);
    logic [2:0] op;
    op = r[11:9];
    if (op >= 3'd6) op = op - 3'd6;
    return {op, r[8:0]};
  endfunction

  // Build an instruction word from the low 12 bits of the LFSR state.
  function automatic logic [11:0] stim_word(input stim_mode_e m,
                                            input logic [31:0] s,
                                            input logic        odd);
    logic [11:0] r;
    r = s[11:0];
    case (m)
      MODE_MEM: return mem_ref_word(r);
      MODE_OP7: return {3'b111, r[8:0]};
      MODE_ALT: return odd ? {3'b111, r[8:0]} : mem_ref_word(r);
      default:  return r;
    endcase
  endfunction

endpackage

// File: rtl/pdp8_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable; a zero seed becomes 1.
module pdp8_lfsr32
  import pdp8_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  localparam logic [31:0] RESET_VAL = (RESET_SEED == 32'h0) ? 32'h1 : RESET_SEED;

  // Load takes priority over stepping; the all-zero lock-up state is never entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/pdp8_stim_sequencer.sv
// Instruction stimulus sequencer: CLA CLL, NOP, then NUM_INSTR pseudo-random words
// offered over a valid/stall handshake with a fixed idle gap after every accept.
// HOLD_CYCLES below 1 is treated as 1 so the hold counter always has a cycle to count.
module pdp8_stim_sequencer
  import pdp8_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 12,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 12'o0200,
  parameter int                    CNT_WIDTH   = 24,
  parameter int                    NUM_INSTR   = 10_000_000,
  parameter int                    HOLD_CYCLES = 4,
  parameter logic [31:0]           SEED        = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  stall,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_word,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  issued_cnt
);

  localparam int                   HOLD_LEN = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int                   HW       = $clog2(HOLD_LEN + 1);
  localparam logic [HW-1:0]        HOLD_INIT = HW'(HOLD_LEN);
  localparam logic [HW-1:0]        HOLD_ONE  = HW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(NUM_INSTR);

  stim_state_e          state;
  stim_state_e          ret_state;
  stim_mode_e           mode_q;
  logic [HW-1:0]        hold_cnt;
  logic [31:0]          lfsr_q;
  logic                 accept;
  logic                 lfsr_load;
  logic                 lfsr_adv;
  logic [CNT_WIDTH-1:0] cnt_next;

  assign base_addr = START_ADDR;

  // Anything other than a clean 0 on stall (including X/Z) blocks the accept.
  assign accept    = instr_valid && (stall === 1'b0);
  assign lfsr_load = (state == IDLE) && start;
  assign lfsr_adv  = (state == RAND) && accept;
  assign cnt_next  = issued_cnt + 1'b1;

  pdp8_lfsr32 #(
    .RESET_SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .seed    (SEED),
    .step    (lfsr_adv),
    .state   (lfsr_q)
  );

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      mode_q      <= MODE_MEM;
      hold_cnt    <= '0;
      instr_valid <= 1'b0;
      instr_word  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      issued_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q      <= stim_mode_e'(mode);
            issued_cnt  <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
            instr_word  <= DATA_WIDTH'(OP_CLA_CLL);
            instr_valid <= 1'b0;
            state       <= PRE_CLA;
          end
        end

        PRE_CLA: begin
          // First cycle here lets the LFSR reload land before anything is offered.
          if (!instr_valid) begin
            instr_valid <= 1'b1;
          end else if (accept) begin
            instr_valid <= 1'b0;
            ret_state   <= PRE_NOP;
            hold_cnt    <= HOLD_INIT;
            state       <= HOLD;
          end
        end

        PRE_NOP: begin
          if (accept) begin
            instr_valid <= 1'b0;
            ret_state   <= RAND;
            hold_cnt    <= HOLD_INIT;
            state       <= HOLD;
          end
        end

        RAND: begin
          if (accept) begin
            instr_valid <= 1'b0;
            issued_cnt  <= (issued_cnt == CNT_LAST) ? issued_cnt : cnt_next;
            if (cnt_next == CNT_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              ret_state <= RAND;
              hold_cnt  <= HOLD_INIT;
              state     <= HOLD;
            end
          end
        end

        HOLD: begin
          // The LFSR and counter already advanced at the accept, so the next
          // random word is built from their current values.
          if (hold_cnt == HOLD_ONE) begin
            instr_valid <= 1'b1;
            instr_word  <= (ret_state == PRE_NOP) ? DATA_WIDTH'(OP_NOP)
                         : DATA_WIDTH'(stim_word(mode_q, lfsr_q, issued_cnt[0]));
            state       <= ret_state;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8_stim_sequencer.sv
// Scoreboard bench for pdp8_stim_sequencer: expected words are queued from an
// independent LFSR/word model at each start and popped on every accept.
module tb_pdp8_stim_sequencer;

  localparam int          NUM      = 64;
  localparam logic [31:0] TB_SEED  = 32'hACE1_0001;
  localparam logic [31:0] TB_TAPS  = 32'h8020_0003;
  localparam int          BUDGET   = 5000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [11:0] instr_word;
  logic [11:0] base_addr;
  logic        busy;
  logic        done;
  logic [23:0] issued_cnt;

  int checks = 0;
  int errors = 0;
  int acc_idx = 0;
  int cur_mode = 0;
  logic [11:0] exp_q[$];

  pdp8_stim_sequencer #(
    .DATA_WIDTH  (12),
    .ADDR_WIDTH  (12),
    .START_ADDR  (12'o0200),
    .CNT_WIDTH   (24),
    .NUM_INSTR   (NUM),
    .HOLD_CYCLES (4),
    .SEED        (TB_SEED)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .mode        (mode),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr_word  (instr_word),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .issued_cnt  (issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelStep(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ TB_TAPS;
    return s >> 1;
  endfunction

  function automatic logic [11:0] memWord(input logic [11:0] r);
    logic [2:0] op;
    op = r[11:9];
    if (op == 3'd6) op = 3'd0;
    if (op == 3'd7) op = 3'd1;
    return {op, r[8:0]};
  endfunction

  function automatic logic [11:0] modelWord(input int m, input logic [31:0] s, input int k);
    logic [11:0] r;
    r = s[11:0];
    case (m)
      0: return memWord(r);
      1: return {3'b111, r[8:0]};
      2: return (k % 2 == 0) ? memWord(r) : {3'b111, r[8:0]};
      default: return r;
    endcase
  endfunction

  task automatic pushRun(input int m);
    logic [31:0] s;
    s = TB_SEED;
    exp_q.push_back(12'o7300);
    exp_q.push_back(12'o7000);
    for (int k = 0; k < NUM; k++) begin
      exp_q.push_back(modelWord(m, s, k));
      s = modelStep(s);
    end
  endtask

  // Accepts are visible at the falling edge before the rising edge that takes them.
  always @(negedge clk) begin
    if (reset_n && instr_valid && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_accept", 32'd1, 32'd0);
      end else begin
        checkOutput("word", {20'd0, instr_word}, {20'd0, exp_q.pop_front()});
      end
      if (acc_idx >= 2) begin
        checkOutput("issued_cnt_run", {8'd0, issued_cnt}, 32'(acc_idx - 2));
        case (cur_mode)
          0: checkOutput("mem_class", {31'd0, instr_word[11:9] <= 3'd5}, 32'd1);
          1: checkOutput("op7_class", {29'd0, instr_word[11:9]}, 32'd7);
          2: if ((acc_idx - 2) % 2 == 0)
               checkOutput("alt_mem", {31'd0, instr_word[11:9] <= 3'd5}, 32'd1);
             else
               checkOutput("alt_op7", {29'd0, instr_word[11:9]}, 32'd7);
          default: ;
        endcase
      end else begin
        checkOutput("issued_cnt_pre", {8'd0, issued_cnt}, 32'd0);
      end
      acc_idx++;
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input bit fresh);
    if (fresh) begin
      pushRun(int'(m));
      acc_idx  = 0;
      cur_mode = int'(m);
    end
    @(posedge clk); #1;
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (fresh) begin
      checkOutput("done_cleared", {31'd0, done}, 32'd0);
      checkOutput("busy_at_start", {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic waitDone(input bit rnd_stall, input int mode_flip_at, input int start_at);
    int  n;
    bit  seen;
    seen = 1'b0;
    n = 0;
    while (n < BUDGET && !seen) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
      end else begin
        stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (n == mode_flip_at) mode = ~mode;
        if (n == start_at) start = 1'b1;
      end
      n++;
    end
    stall = 1'b0;
    start = 1'b0;
    if (!seen) begin
      checkOutput("timeout_done", 32'd0, 32'd1);
    end else begin
      checkOutput("final_cnt", {8'd0, issued_cnt}, NUM);
      checkOutput("final_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("final_busy", {31'd0, busy}, 32'd0);
      checkOutput("queue_drained", exp_q.size(), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("done_sticky", {31'd0, done}, 32'd1);
      checkOutput("cnt_held", {8'd0, issued_cnt}, NUM);
    end
  endtask

  initial begin
    bit exp_valid[12];
    int n;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_cnt", {8'd0, issued_cnt}, 32'd0);
    checkOutput("rst_base", {20'd0, base_addr}, 32'o0200);
    reset_n = 1'b1;

    $display("[TB] preamble timing, mode 01");
    exp_valid = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    applyStimulus(2'b01, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput($sformatf("pre_valid_%0d", i), {31'd0, instr_valid}, {31'd0, exp_valid[i]});
    end
    waitDone(1'b0, -1, -1);

    $display("[TB] stall hold on CLA CLL, mode 00 with random stall");
    stall = 1'b1;
    applyStimulus(2'b00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("stall_word", {20'd0, instr_word}, 32'o7300);
      checkOutput("stall_no_accept", acc_idx, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    checkOutput("released_accept", acc_idx, 32'd1);
    checkOutput("released_valid", {31'd0, instr_valid}, 32'd0);
    waitDone(1'b1, 20, -1);

    $display("[TB] mode 10, random stall");
    applyStimulus(2'b10, 1'b1);
    waitDone(1'b1, 40, -1);

    $display("[TB] mode 11 with start pulse while busy");
    applyStimulus(2'b11, 1'b1);
    waitDone(1'b0, -1, 30);

    $display("[TB] mode 11 restart reseeds");
    applyStimulus(2'b11, 1'b1);
    waitDone(1'b0, -1, -1);

    $display("[TB] reset mid-run");
    applyStimulus(2'b11, 1'b1);
    n = 0;
    while (n < BUDGET && acc_idx < 5) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("midrun_reached", {31'd0, acc_idx >= 5}, 32'd1);
    @(posedge clk); #2;
    checkOutput("midrun_hold_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("midrun_busy", {31'd0, busy}, 32'd1);
    checkOutput("midrun_cnt", {8'd0, issued_cnt}, 32'd3);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_cnt", {8'd0, issued_cnt}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] clean run after abort, mode 01");
    applyStimulus(2'b01, 1'b1);
    waitDone(1'b1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
